// File: rtl/ffmul_32bit_seq.sv
// ffmul_32bit_seq
// Sequential IEEE-754 single-precision multiplier. A start request captures
// two operands. The operands are classified and normalised (subnormals are
// shifted up until their leading one sits at bit 23). The 48-bit significand
// product is then built by a radix-2 shift-add engine, one multiplier bit per
// cycle. Finally the product is normalised and rounded to nearest-even.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, aborts any operation
//   op_1, op_2  operands, sampled in IDLE when mul_start=1
//   mul_start   level request, ignored outside IDLE
//   sign, biased_exp, fraction
//               registered result fields, hold until the next result
//   mul_ready   high only while in DONE
//   count       shift-add iterations performed in the current operation
module ffmul_32bit_seq #(
    parameter int OPERAND_WIDTH     = 32,
    parameter int EXP_WIDTH         = 8,
    parameter int SIGNIFICAND_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OPERAND_WIDTH-1:0]     op_1,
    input  logic [OPERAND_WIDTH-1:0]     op_2,
    input  logic                         mul_start,
    output logic                         sign,
    output logic [EXP_WIDTH-1:0]         biased_exp,
    output logic [SIGNIFICAND_WIDTH-2:0] fraction,
    output logic                         mul_ready,
    output logic [4:0]                   count
);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

    state_t             state_reg;
    logic [31:0]        op_reg [2];
    logic               sign_reg;
    logic signed [9:0]  exp_reg;
    logic [23:0]        mcand_reg;
    logic [23:0]        mplier_reg;   // multiplier, becomes low product half
    logic [23:0]        acc_reg;      // upper partial product
    logic [23:0]        sig_reg;
    logic               guard_reg;
    logic               sticky_reg;
    logic               sub_reg;

    // Shift that moves the highest set bit of a nonzero fraction up to bit 23.
    function automatic logic [4:0] lzc_shift(input logic [22:0] f);
        logic [4:0] s;
        s = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (f[i]) s = 5'(23 - i);
        end
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Operand classification and normalisation
    // ------------------------------------------------------------------
    logic [1:0]        is_nan;
    logic [1:0]        is_inf;
    logic [1:0]        is_zero;
    logic [1:0]        is_denorm;
    logic [1:0]        op_sign;
    logic [23:0]       unp_sig [2];
    logic signed [9:0] unp_exp [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            logic [7:0]  e_field;
            logic [22:0] f_field;
            logic [4:0]  shift;

            assign e_field       = op_reg[gi][30:23];
            assign f_field       = op_reg[gi][22:0];
            assign op_sign[gi]   = op_reg[gi][31];
            assign is_nan[gi]    = (e_field == 8'hFF) && (f_field != 23'd0);
            assign is_inf[gi]    = (e_field == 8'hFF) && (f_field == 23'd0);
            assign is_zero[gi]   = (e_field == 8'h00) && (f_field == 23'd0);
            assign is_denorm[gi] = (e_field == 8'h00) && (f_field != 23'd0);
            assign shift         = lzc_shift(f_field);
            assign unp_sig[gi]   = is_denorm[gi] ? ({1'b0, f_field} << shift)
                                                 : {1'b1, f_field};
            assign unp_exp[gi]   = is_denorm[gi] ? (10'sd1 - $signed({5'b0, shift}))
                                                 : $signed({2'b0, e_field});
        end
    endgenerate

    logic              res_sign;
    logic              nan_result;
    logic signed [9:0] exp_sum;

    assign res_sign   = op_sign[0] ^ op_sign[1];
    assign nan_result = (|is_nan) || (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);
    assign exp_sum    = unp_exp[0] + unp_exp[1] - 10'sd127;

    // ------------------------------------------------------------------
    // Shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift {sum, multiplier} right by one.
    // ------------------------------------------------------------------
    logic [24:0] mult_sum;
    assign mult_sum = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : 25'd0);

    // ------------------------------------------------------------------
    // Normalisation, including the subnormal denormalising shift
    // ------------------------------------------------------------------
    logic [23:0]       n_sig;
    logic              n_guard;
    logic              n_sticky;
    logic signed [9:0] n_exp;
    logic              n_sub;
    logic signed [9:0] n_shamt;
    logic [5:0]        n_sh;
    logic [88:0]       n_shifted;
    logic [23:0]       s_sig;
    logic              s_guard;
    logic              s_sticky;

    always_comb begin
        n_sig    = 24'd0;
        n_guard  = 1'b0;
        n_sticky = 1'b0;
        n_exp    = exp_reg;
        if (acc_reg[23]) begin
            n_sig    = acc_reg;
            n_guard  = mplier_reg[23];
            n_sticky = |mplier_reg[22:0];
            n_exp    = exp_reg + 10'sd1;
        end else begin
            n_sig    = {acc_reg[22:0], mplier_reg[23]};
            n_guard  = mplier_reg[22];
            n_sticky = |mplier_reg[21:0];
        end
        n_sub   = (n_exp < 10'sd1);
        n_shamt = 10'sd1 - n_exp;
        // 64 zero bits below the guard hold every bit of any shift up to 63,
        // and beyond that the result is all-sticky anyway.
        n_sh      = (n_shamt > 10'sd63) ? 6'd63 : n_shamt[5:0];
        n_shifted = {n_sig, n_guard, 64'd0} >> n_sh;
        if (n_sub) begin
            s_sig    = n_shifted[88:65];
            s_guard  = n_shifted[64];
            s_sticky = n_sticky | (|n_shifted[63:0]);
        end else begin
            s_sig    = n_sig;
            s_guard  = n_guard;
            s_sticky = n_sticky;
        end
    end

    // ------------------------------------------------------------------
    // Round to nearest-even and overflow detection
    // ------------------------------------------------------------------
    logic              r_inc;
    logic [24:0]       r_sum;
    logic signed [9:0] r_exp;
    logic [7:0]        r_exp_field;
    logic [22:0]       r_frac;

    always_comb begin
        r_inc       = guard_reg & (sticky_reg | sig_reg[0]);
        r_sum       = {1'b0, sig_reg} + {24'd0, r_inc};
        r_exp       = exp_reg;
        r_frac      = r_sum[22:0];
        r_exp_field = 8'd0;
        if (sub_reg) begin
            // Rounding a subnormal up into bit 23 makes it the smallest normal.
            r_exp_field = r_sum[23] ? 8'd1 : 8'd0;
        end else begin
            if (r_sum[24]) begin
                r_exp  = exp_reg + 10'sd1;
                r_frac = r_sum[23:1];
            end
            if (r_exp >= 10'sd255) begin
                r_exp_field = 8'hFF;
                r_frac      = 23'd0;
            end else begin
                r_exp_field = r_exp[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg[0]  <= 32'd0;
            op_reg[1]  <= 32'd0;
            sign_reg   <= 1'b0;
            exp_reg    <= 10'sd0;
            mcand_reg  <= 24'd0;
            mplier_reg <= 24'd0;
            acc_reg    <= 24'd0;
            sig_reg    <= 24'd0;
            guard_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            sub_reg    <= 1'b0;
            sign       <= 1'b0;
            biased_exp <= '0;
            fraction   <= '0;
            mul_ready  <= 1'b0;
            count      <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mul_start) begin
                        op_reg[0] <= op_1;
                        op_reg[1] <= op_2;
                        count     <= 5'd0;
                        state_reg <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_reg <= res_sign;
                    if (nan_result) begin
                        sign       <= 1'b0;
                        biased_exp <= 8'hFF;
                        fraction   <= 23'h400000;
                        mul_ready  <= 1'b1;
                        state_reg  <= DONE;
                    end else if (|is_inf) begin
                        sign       <= res_sign;
                        biased_exp <= 8'hFF;
                        fraction   <= 23'd0;
                        mul_ready  <= 1'b1;
                        state_reg  <= DONE;
                    end else if (|is_zero) begin
                        sign       <= res_sign;
                        biased_exp <= 8'h00;
                        fraction   <= 23'd0;
                        mul_ready  <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        mcand_reg  <= unp_sig[0];
                        mplier_reg <= unp_sig[1];
                        acc_reg    <= 24'd0;
                        exp_reg    <= exp_sum;
                        state_reg  <= MULT;
                    end
                end
                MULT: begin
                    acc_reg    <= mult_sum[24:1];
                    mplier_reg <= {mult_sum[0], mplier_reg[23:1]};
                    count      <= count + 5'd1;
                    if (count == 5'd23) state_reg <= NORM;
                end
                NORM: begin
                    sig_reg    <= s_sig;
                    guard_reg  <= s_guard;
                    sticky_reg <= s_sticky;
                    sub_reg    <= n_sub;
                    exp_reg    <= n_sub ? 10'sd0 : n_exp;
                    state_reg  <= ROUND;
                end
                ROUND: begin
                    sign       <= sign_reg;
                    biased_exp <= r_exp_field;
                    fraction   <= r_frac;
                    mul_ready  <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    if (!mul_start) begin
                        mul_ready <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffmul_32bit_seq.sv
// Directed bench for ffmul_32bit_seq. Stimulus pushes the hand-computed
// result, expected latency and expected iteration count into a queue. An
// independent monitor pops and compares whenever mul_ready is seen.
module tb_ffmul_32bit_seq;

    logic        clk;
    logic        rst;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic        mul_start;
    logic        sign;
    logic [7:0]  biased_exp;
    logic [22:0] fraction;
    logic        mul_ready;
    logic [4:0]  count;

    ffmul_32bit_seq dut (
        .clk        (clk),
        .rst        (rst),
        .op_1       (op_1),
        .op_2       (op_2),
        .mul_start  (mul_start),
        .sign       (sign),
        .biased_exp (biased_exp),
        .fraction   (fraction),
        .mul_ready  (mul_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        logic [4:0]  cnt;
        int          start;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Monitor / scoreboard
    exp_t        mon_e;
    logic [31:0] mon_res;
    always @(negedge clk) begin
        if (!rst && mul_ready) begin
            mon_res = {sign, biased_exp, fraction};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready result=%08h required no result", mon_res);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (mon_res !== mon_e.res) begin
                    n_fail++;
                    $display("FAIL op%0d_result got=%08h exp=%08h", mon_e.idx, mon_res, mon_e.res);
                end
                n_checks++;
                if (edge_cnt - mon_e.start != mon_e.lat) begin
                    n_fail++;
                    $display("FAIL op%0d_latency got=%0d exp=%0d", mon_e.idx, edge_cnt - mon_e.start, mon_e.lat);
                end
                n_checks++;
                if (count !== mon_e.cnt) begin
                    n_fail++;
                    $display("FAIL op%0d_count got=%0d exp=%0d", mon_e.idx, count, mon_e.cnt);
                end
                $display("op%0d: result=%08h latency=%0d count=%0d", mon_e.idx, mon_res,
                         edge_cnt - mon_e.start, count);
                done_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", name, got, want);
        end
    endtask

    // Called shortly after a rising edge with the DUT in IDLE.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input logic [4:0] cnt);
        exp_t e;
        int   target;
        op_1      = a;
        op_2      = b;
        mul_start = 1'b1;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        op_1      = $urandom;
        op_2      = $urandom;
        e.res   = res;
        e.lat   = lat;
        e.cnt   = cnt;
        e.start = edge_cnt;
        e.idx   = idx;
        exp_q.push_back(e);
        target = done_cnt + 1;
        for (int i = 0; i < 60 && done_cnt < target; i++) @(posedge clk);
        #1;
        if (done_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL op%0d_timeout got=no mul_ready exp=mul_ready within 60 cycles", idx);
            exp_q.delete();
        end else begin
            check($sformatf("op%0d_ready_fall", idx), {31'd0, mul_ready}, 32'd0);
            check($sformatf("op%0d_hold", idx), {sign, biased_exp, fraction}, res);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=time limit exp=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mul_start = 1'b0;
        op_1      = 32'd0;
        op_2      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_result", {sign, biased_exp, fraction}, 32'd0);
        check("reset_ready_count", {26'd0, mul_ready, count}, 32'd0);

        do_op(0, 32'h40400000, 32'h40200000, 32'h40F00000, 27, 5'd24);
        do_op(1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 27, 5'd24);
        do_op(2, 32'h7F800000, 32'h80000000, 32'h7FC00000, 1,  5'd0);
        do_op(3, 32'hFF800000, 32'h40000000, 32'hFF800000, 1,  5'd0);
        do_op(4, 32'h7F000000, 32'h40000000, 32'h7F800000, 27, 5'd24);
        do_op(5, 32'h00800000, 32'h3F000000, 32'h00400000, 27, 5'd24);
        do_op(6, 32'h00000001, 32'h4B000000, 32'h00800000, 27, 5'd24);
        do_op(7, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1,  5'd0);
        do_op(8, 32'h80000000, 32'h40000000, 32'h80000000, 1,  5'd0);
        do_op(9, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 27, 5'd24);
        do_op(10, 32'h3F800001, 32'h3FFFFFFF, 32'h40000000, 27, 5'd24);

        // Abort an operation with rst sampled at its edge 10.
        op_1      = 32'h40400000;
        op_2      = 32'h40200000;
        mul_start = 1'b1;
        @(posedge clk);           // edge 0
        #1;
        mul_start = 1'b0;
        repeat (9) @(posedge clk); // edge 9
        #1;
        check("midop_count", {27'd0, count}, 32'd8);
        rst = 1'b1;
        @(posedge clk);           // edge 10
        #1;
        rst = 1'b0;
        check("abort_result", {sign, biased_exp, fraction}, 32'd0);
        check("abort_ready_count", {26'd0, mul_ready, count}, 32'd0);
        check("abort_state", {29'd0, dut.state_reg}, 32'd0);
        $display("abort: outputs cleared after rst");

        // New request issued on the first cycle after rst drops.
        do_op(11, 32'h40400000, 32'h40200000, 32'h40F00000, 27, 5'd24);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
